// File: rtl/gui_pkg.sv
// -----------------------------------------------------------------------------
// gui_pkg
// Shared definitions for the GUI output stage.
//   - RGB_W / CH_W / LEVEL_W : pixel, colour-channel and brightness-level widths
//   - LEVEL_MAX              : brightness level that passes a pixel unchanged
//   - screen_state_t         : screen-change FSM states
//   - screen_src_t           : which rendered stream feeds the output
//   - scale_channel()        : one colour channel times a brightness level
// -----------------------------------------------------------------------------
package gui_pkg;

  localparam int RGB_W   = 12;
  localparam int CH_W    = 4;
  localparam int LEVEL_W = 5;
  localparam int PROD_W  = 8;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;

  typedef enum logic [1:0] {
    ST_MENU     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_FADE_IN  = 2'd2,
    ST_GAME     = 2'd3
  } screen_state_t;

  typedef enum logic {
    SRC_MENU = 1'b0,
    SRC_MAP  = 1'b1
  } screen_src_t;

  // c_out = (c * level) >> 4. With level = 16 the product is c << 4, so the
  // upper nibble is c itself and no special identity case is needed.
  function automatic logic [CH_W-1:0] scale_channel(input logic [CH_W-1:0]    c,
                                                     input logic [LEVEL_W-1:0] level);
    logic [PROD_W-1:0] prod;
    prod = {{(PROD_W-CH_W){1'b0}}, c} * {{(PROD_W-LEVEL_W){1'b0}}, level};
    return prod[PROD_W-1:PROD_W-CH_W];
  endfunction

endpackage

// File: rtl/rgb_scaler.sv
// -----------------------------------------------------------------------------
// rgb_scaler
// Registered brightness scaler: each 4-bit channel of a 12-bit pixel is
// multiplied by a 0..16 level and the top nibble of the product is kept.
// Ports:
//   clk, rst  : pixel clock, asynchronous active-high reset
//   rgb_in    : 12-bit pixel {R4,G4,B4}
//   level     : 5-bit brightness level, 16 = unchanged, 0 = black
//   rgb_out   : scaled pixel, one cycle after rgb_in/level
// -----------------------------------------------------------------------------
module rgb_scaler
  import gui_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [LEVEL_W-1:0] level,
  output logic [RGB_W-1:0]   rgb_out
);

  logic [RGB_W-1:0] scaled;

  genvar gi;
  generate
    for (gi = 0; gi < RGB_W / CH_W; gi++) begin : g_channel
      assign scaled[gi*CH_W +: CH_W] = scale_channel(rgb_in[gi*CH_W +: CH_W], level);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out <= '0;
    end else begin
      rgb_out <= scaled;
    end
  end

endmodule

// File: rtl/screen_select.sv
// -----------------------------------------------------------------------------
// screen_select
// VGA output stage: picks the menu or map pixel stream, forces black during
// blanking and changes screen only at a frame boundary (rising vblnk_in).
// Fixed two-cycle latency from timing/pixel inputs to outputs.
//
// Build option:
//   SCREEN_FADE_EN defined   : screen change fades brightness 16 -> 0, swaps
//                              the source, then fades 0 -> 16, spending
//                              FRAMES_PER_STEP frames at each level.
//   SCREEN_FADE_EN undefined : hard cut at the boundary, no scaler.
//
// Ports:
//   clk, rst            : pixel clock, asynchronous active-high reset
//   hcount_in/vcount_in : pixel position (debug only, not used by the logic)
//   hblnk_in/vblnk_in   : blanking; rising vblnk_in marks a frame boundary
//   hsync_in/vsync_in   : syncs, delayed 2 cycles to hsync_out/vsync_out
//   rgb_map/rgb_menu    : rendered pixel streams, aligned with timing inputs
//   start_game          : pulse, request menu -> game (accepted in MENU)
//   exit_to_menu        : pulse, request game -> menu (accepted in GAME)
//   rgb_out             : final pixel, aligned with hsync_out/vsync_out
//   screen_is_game      : 1 while the game screen is settled
//   busy                : 1 while a change is pending or fading
// -----------------------------------------------------------------------------
module screen_select
  import gui_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [RGB_W-1:0] rgb_map,
  input  logic [RGB_W-1:0] rgb_menu,
  input  logic             start_game,
  input  logic             exit_to_menu,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             screen_is_game,
  output logic             busy
);

  // Position inputs are kept on the port list for debug probing only.
  logic unused_debug;
  assign unused_debug = ^{hcount_in, vcount_in};

  screen_state_t    state_reg;
  screen_src_t      src_reg;
  logic             pending_reg;
  logic             busy_reg;
  logic             game_reg;
  logic             vblnk_prev_reg;
  logic             boundary_reg;
  logic             request;

  logic [RGB_W-1:0] rgb_s1_reg;
  logic             blank_s1_reg;
  logic             hsync_s1_reg;
  logic             vsync_s1_reg;
  logic [RGB_W-1:0] rgb_s1_gated;

  assign screen_is_game = game_reg;
  assign busy           = busy_reg;

  // A request only counts if it asks to leave the screen currently shown.
  assign request = ((state_reg == ST_MENU) && start_game) ||
                   ((state_reg == ST_GAME) && exit_to_menu);

  // Boundary is flagged one cycle after vblnk_in rises, still inside blanking,
  // so source/level updates never land on a visible pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_prev_reg <= 1'b0;
      boundary_reg   <= 1'b0;
    end else begin
      vblnk_prev_reg <= vblnk_in;
      boundary_reg   <= vblnk_in & ~vblnk_prev_reg;
    end
  end

  // Stage 1: select source, capture blank and syncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_s1_reg   <= '0;
      blank_s1_reg <= 1'b0;
      hsync_s1_reg <= 1'b0;
      vsync_s1_reg <= 1'b0;
    end else begin
      rgb_s1_reg   <= (src_reg == SRC_MAP) ? rgb_map : rgb_menu;
      blank_s1_reg <= hblnk_in | vblnk_in;
      hsync_s1_reg <= hsync_in;
      vsync_s1_reg <= vsync_in;
    end
  end

  // Blanked pixels are zeroed before stage 2; zero stays zero at any level.
  assign rgb_s1_gated = blank_s1_reg ? '0 : rgb_s1_reg;

  // Stage 2: syncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      hsync_out <= hsync_s1_reg;
      vsync_out <= vsync_s1_reg;
    end
  end

`ifdef SCREEN_FADE_EN

  localparam int FCNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FCNT_W-1:0]  FCNT_LAST  = FCNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_MAX - 5'd1;

  logic [LEVEL_W-1:0] level_reg;
  logic [FCNT_W-1:0]  frame_cnt_reg;

  // Stage 2: scaled pixel.
  rgb_scaler u_scaler (
    .clk     (clk),
    .rst     (rst),
    .rgb_in  (rgb_s1_gated),
    .level   (level_reg),
    .rgb_out (rgb_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_MENU;
      src_reg       <= SRC_MENU;
      level_reg     <= LEVEL_MAX;
      frame_cnt_reg <= '0;
      pending_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      game_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_MENU, ST_GAME: begin
          if (boundary_reg && pending_reg) begin
            state_reg     <= ST_FADE_OUT;
            pending_reg   <= 1'b0;
            frame_cnt_reg <= '0;
            busy_reg      <= 1'b1;
            game_reg      <= 1'b0;
          end else if (request) begin
            pending_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        ST_FADE_OUT: begin
          if (boundary_reg) begin
            if (level_reg == '0) begin
              // Fully dark: swap the source while nothing is visible.
              src_reg       <= (src_reg == SRC_MENU) ? SRC_MAP : SRC_MENU;
              state_reg     <= ST_FADE_IN;
              frame_cnt_reg <= '0;
            end else if (frame_cnt_reg == FCNT_LAST) begin
              frame_cnt_reg <= '0;
              level_reg     <= level_reg - 5'd1;
            end else begin
              frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
          end
        end
        ST_FADE_IN: begin
          if (boundary_reg) begin
            if (frame_cnt_reg == FCNT_LAST) begin
              frame_cnt_reg <= '0;
              level_reg     <= level_reg + 5'd1;
              if (level_reg == LEVEL_LAST) begin
                state_reg <= (src_reg == SRC_MAP) ? ST_GAME : ST_MENU;
                game_reg  <= (src_reg == SRC_MAP);
                busy_reg  <= 1'b0;
              end
            end else begin
              frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_MENU;
      endcase
    end
  end

`else

  // Stage 2: pixel passes straight through at full brightness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out <= '0;
    end else begin
      rgb_out <= rgb_s1_gated;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_MENU;
      src_reg     <= SRC_MENU;
      pending_reg <= 1'b0;
      busy_reg    <= 1'b0;
      game_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_MENU: begin
          if (boundary_reg && pending_reg) begin
            state_reg   <= ST_GAME;
            src_reg     <= SRC_MAP;
            game_reg    <= 1'b1;
            pending_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end else if (request) begin
            pending_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        ST_GAME: begin
          if (boundary_reg && pending_reg) begin
            state_reg   <= ST_MENU;
            src_reg     <= SRC_MENU;
            game_reg    <= 1'b0;
            pending_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end else if (request) begin
            pending_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        default: state_reg <= ST_MENU;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_screen_select.sv
// -----------------------------------------------------------------------------
// tb_screen_select
// Drives a miniature video raster with random pixel streams and request
// pulses, and compares every output cycle against a frame-level model of the
// screen/brightness schedule. Works with or without SCREEN_FADE_EN.
// -----------------------------------------------------------------------------
module tb_screen_select;

  localparam int FPS   = 1;
  localparam int H_TOT = 24;
  localparam int H_ACT = 16;
  localparam int V_TOT = 8;
  localparam int V_ACT = 6;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        hblnk_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [11:0] rgb_map = '0;
  logic [11:0] rgb_menu = '0;
  logic        start_game = 1'b0;
  logic        exit_to_menu = 1'b0;
  logic        hsync_out;
  logic        vsync_out;
  logic [11:0] rgb_out;
  logic        screen_is_game;
  logic        busy;

  always #5 clk = ~clk;

  screen_select #(.FRAMES_PER_STEP(FPS)) dut (
    .clk            (clk),
    .rst            (rst),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .hblnk_in       (hblnk_in),
    .vblnk_in       (vblnk_in),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .rgb_map        (rgb_map),
    .rgb_menu       (rgb_menu),
    .start_game     (start_game),
    .exit_to_menu   (exit_to_menu),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .rgb_out        (rgb_out),
    .screen_is_game (screen_is_game),
    .busy           (busy)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model (frame granularity) ----------------
  bit m_game    = 0;   // settled screen is the game
  bit m_pending = 0;
  bit m_fading  = 0;
  int m_k       = 0;   // boundaries since the fade was triggered
  bit cur_src   = 0;   // 1 = map shown this frame
  int cur_level = 16;

  // Fade schedule: level 16 - k/FPS down to 0 at k = 16*FPS; the next
  // boundary swaps the screen at level 0; then +1 every FPS frames to 16.
  task automatic model_boundary();
    if (!m_fading) begin
      if (m_pending) begin
        m_pending = 0;
`ifdef SCREEN_FADE_EN
        m_fading = 1;
        m_k      = 0;
`else
        m_game  = !m_game;
        cur_src = m_game;
`endif
      end
    end else begin
      m_k++;
      if (m_k <= 16 * FPS) begin
        cur_level = 16 - m_k / FPS;
      end else begin
        cur_src   = !m_game;
        cur_level = (m_k - (16 * FPS + 1)) / FPS;
        if (cur_level >= 16) begin
          cur_level = 16;
          m_fading  = 0;
          m_game    = !m_game;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_game = 0; m_pending = 0; m_fading = 0; m_k = 0;
    cur_src = 0; cur_level = 16;
  endtask

  function automatic logic [11:0] scale(input logic [11:0] p, input int lvl);
    int r, g, b;
    r = int'(p[11:8]) * lvl / 16;
    g = int'(p[7:4])  * lvl / 16;
    b = int'(p[3:0])  * lvl / 16;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  // ---------------- cycle driver / scoreboard ----------------
  typedef struct packed {
    logic [13:0] v;     // {hsync, vsync, rgb}
    logic        chk;   // also compare against a fixed constant
    logic        f80;
    logic [11:0] cv;
  } exp_t;

  exp_t q[$];
  int hc = 0;
  int vc = 0;
  bit vb_prev = 0;
  int fix_mode = 0;     // 0 random menu, 1 menu=ABC, 2 menu=F80 at level 8

  task automatic cycle(input bit sg, input bit ex);
    exp_t        e;
    logic [11:0] mv;
    logic [11:0] pix;
    bit          blank;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      check_value("pix", 32'({hsync_out, vsync_out, rgb_out}), 32'(e.v));
      if (e.chk)
        check_value(e.f80 ? "lvl8_f80" : "menu_abc", 32'(rgb_out), 32'(e.cv));
    end
    if (hc == 4 && vc < V_ACT) begin
      check_value("busy", 32'(busy), 32'(m_pending | m_fading));
      check_value("is_game", 32'(screen_is_game), 32'(m_game & !m_fading));
    end
    hcount_in = 11'(hc);
    vcount_in = 10'(vc);
    hblnk_in  = (hc >= H_ACT);
    vblnk_in  = (vc >= V_ACT);
    hsync_in  = (hc >= H_ACT + 2) && (hc < H_ACT + 5);
    vsync_in  = (vc == V_ACT + 1);
    if (vblnk_in && !vb_prev) model_boundary();
    vb_prev = vblnk_in;
    blank = hblnk_in | vblnk_in;
    e = '0;
    mv = 12'($urandom);
    if (fix_mode == 1) begin
      mv = 12'hABC; e.chk = 1; e.cv = blank ? 12'h000 : 12'hABC;
    end else if (fix_mode == 2 && !cur_src && cur_level == 8) begin
      mv = 12'hF80; e.chk = 1; e.f80 = 1; e.cv = blank ? 12'h000 : 12'h740;
    end
    rgb_menu     = mv;
    rgb_map      = 12'($urandom);
    start_game   = sg;
    exit_to_menu = ex;
    if (sg && !m_fading && !m_game) m_pending = 1;
    if (ex && !m_fading && m_game)  m_pending = 1;
    pix = blank ? 12'h000 : scale(cur_src ? rgb_map : rgb_menu, cur_level);
    e.v = {hsync_in, vsync_in, pix};
    q.push_back(e);
    hc++;
    if (hc == H_TOT) begin
      hc = 0;
      vc++;
      if (vc == V_TOT) vc = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0);
  endtask

  // Advance to a random mid-frame position, then pulse (optionally only
  // while a fade is running, so the pulse is always one that gets dropped).
  task automatic pulse_at(input bit sg, input bit ex, input bit only_fading);
    int target;
    int guard;
    bit fire;
    target = $urandom_range(2, H_ACT - 3);
    guard  = 0;
    while (!(vc == 2 && hc == target) && guard < 3 * FRAME) begin
      cycle(0, 0);
      guard++;
    end
    check_value("pos_reached", 32'(guard < 3 * FRAME), 32'd1);
    fire = !only_fading || m_fading;
    cycle(sg & fire, ex & fire);
  endtask

  task automatic wait_settled(input bit noisy);
    int guard;
    int r;
    guard = 0;
    while ((m_fading || m_pending) && guard < 80) begin
      fix_mode = 2;
      r = noisy ? $urandom_range(0, 3) : 0;
      pulse_at(r == 1, r == 2, 1);
      guard++;
    end
    fix_mode = 0;
    check_value("settle_in_time", 32'(guard < 80), 32'd1);
  endtask

  initial begin
    int guard;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_rgb", 32'(rgb_out), 32'h0);
    check_value("rst_sync", 32'({hsync_out, vsync_out}), 32'h0);
    check_value("rst_busy", 32'(busy), 32'h0);
    check_value("rst_game", 32'(screen_is_game), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Steady menu with a fixed pixel, then random pixels
    fix_mode = 1;
    run_cycles(FRAME);
    fix_mode = 0;
    run_cycles(FRAME);

    // exit_to_menu in MENU is ignored
    pulse_at(0, 1, 0);
    run_cycles(FRAME);

    // menu -> game, with dropped requests sprinkled through the fade
    pulse_at(1, 0, 0);
    wait_settled(1);
    run_cycles(FRAME);

    // start_game in GAME is ignored, then game -> menu
    pulse_at(1, 0, 0);
    run_cycles(FRAME);
    pulse_at(0, 1, 0);
    wait_settled(1);
    run_cycles(FRAME);

    // menu -> game again, reset part-way through
    pulse_at(1, 0, 0);
    guard = 0;
`ifdef SCREEN_FADE_EN
    while (!(m_fading && m_k > 16 * FPS && cur_level == 9) && guard < 80) begin
`else
    while (!m_game && guard < 80) begin
`endif
      pulse_at(0, 0, 0);
      guard++;
    end
    check_value("reach_rst_point", 32'(guard < 80), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_value("midrst_rgb", 32'(rgb_out), 32'h0);
    check_value("midrst_sync", 32'({hsync_out, vsync_out}), 32'h0);
    check_value("midrst_busy", 32'(busy), 32'h0);
    check_value("midrst_game", 32'(screen_is_game), 32'h0);
    model_reset();
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_cycles(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
